ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- AHB-Lite slave that sits directly downstream of ahb_master. It consumes the master's address/control/write-data phases and returns hreadyout, hresp and hrdata.
- Backs a word-organised on-chip RAM with byte-lane writes.
- Supports programmable wait states, the two-cycle ERROR response, and read-after-write forwarding across pipelined transfers.

Parameters:
- ADDR_W, 6, word-address width; RAM depth = 2**ADDR_W words (default 64 x 32 bit).
- WAIT_STATES, 0, number of hreadyout=0 cycles inserted per OKAY transfer (0..7).

Ports:
- hclk  in  1  system clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- hselx  in  1  slave select from decoder (master sel decoded).
- haddr  in  32  byte address.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- hburst  in  3  burst type; accepted, ignored.
- hprot  in  4  protection; accepted, ignored.
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hready  in  1  bus-wide ready (previous data phase done).
- hwdata  in  32  write data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset (async, hresetn=0): FSM=IDLE, hreadyout=1, hresp=0, hrdata=0, pending-transfer registers cleared. RAM contents are not reset.
- Address phase is accepted on a rising edge with hselx=1, hready=1, htrans[1]=1. Sampled into registers: address, hwrite, hsize, byte enables, error flag.
- IDLE/BUSY or hselx=0: no transfer is accepted; the next cycle gives a zero-wait OKAY.
- Error is detected at accept time when any of the following hold:
  - hsize > 2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0] != 0;
  - haddr[31:ADDR_W+2] != 0.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: accept with error -> ERR1. Accept OK with WAIT_STATES>0 -> WAIT, with counter loaded to WAIT_STATES-1. Accept OK with WAIT_STATES=0 -> stays IDLE, and the data phase completes next cycle with hreadyout=1.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 the next cycle drives hreadyout=1 (data phase done) and the FSM returns to IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1 -> IDLE.
- Pipelining: a new address phase may be accepted on the same edge that ends the previous data phase (hready=1). Back-to-back transfers sustain one per cycle with WAIT_STATES=0.
- Write commit: RAM is updated on the edge ending the data phase. Only byte lanes enabled by hsize/haddr[1:0] are written, little-endian (byte n -> hwdata[8n+7:8n]). Errored writes never touch RAM.
- Read: RAM word is captured into hrdata at the edge before the completing cycle. hrdata always returns the full 32-bit word. Errored reads: hrdata=0.
- RAW forwarding: if a read is accepted on the same edge a write commits to the same word, the committing write's enabled lanes of hwdata replace the RAM bytes in hrdata.
- Master abandons after ERR1 (htrans=IDLE in ERR2): must be honoured, no extra transfer.
- Reset asserted mid-transfer: pending transfer dropped, an uncommitted write is lost, outputs go to reset values immediately.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes (BYTE/HALF/WORD);
  - HRESP codes (OKAY/ERROR);
  - slave FSM state encoding.
- One sub-module, ahb_lite_lane_decode: combinational. Maps hsize and haddr[1:0] to a 4-bit byte-enable plus an alignment-error flag. Shared with future slaves.

Test Plan:
- Reset, then word write NONSEQ haddr=0x24 hwdata=0xDEADBEEF, then read 0x24 -> hrdata=0xDEADBEEF, hresp=0, hreadyout=1 each data phase, no wait cycles.
- Byte write 0x11 to haddr=0x25, then word read 0x24 -> 0xDEAD11EF. Halfword write 0xCAFE to 0x26, then read -> 0xCAFE11EF.
- Back-to-back write 0x10=0x12345678 with read 0x10 accepted on the commit edge -> read returns 0x12345678 (forwarding).
- Word access at haddr=0x02 -> cycle 1 hreadyout=0 hresp=1, cycle 2 hreadyout=1 hresp=1; RAM at 0x00 unchanged on re-read. Same two-cycle ERROR for haddr=0x100 (out of range with ADDR_W=6).
- WAIT_STATES=2: write then read of 0x08 -> exactly 2 cycles of hreadyout=0 before each completion; data correct.
- Assert hresetn low during a WAIT cycle of a write to 0x0C -> hreadyout=1, hresp=0, hrdata=0 immediately; later read of 0x0C returns its prior value.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and slave-side types.
// Contents: HTRANS / HSIZE / HRESP codes, SRAM slave FSM encoding,
// and the byte-lane selection record produced by the lane decoder.
package ahb_lite_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LANES      = DATA_W / 8;
    localparam int unsigned WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // Byte enables plus alignment error for one transfer
    typedef struct packed {
        logic [LANES-1:0] be;
        logic             align_err;
    } lane_sel_t;

endpackage

// File: rtl/ahb_lite_lane_decode.sv
// Combinational byte-lane decoder for 32-bit AHB-Lite slaves.
// Ports:
//   size    in  3  HSIZE of the transfer
//   addr_lo in  2  haddr[1:0]
//   sel     out    byte enables (little-endian) and alignment-error flag
module ahb_lite_lane_decode
    import ahb_lite_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output lane_sel_t  sel
);

    // Lane mapping; unsupported sizes and misaligned accesses flag an error
    always_comb begin : decode
        sel = '0;
        case (size)
            HSIZE_BYTE: sel.be = LANES'(4'b0001 << addr_lo);
            HSIZE_HALF: begin
                if (addr_lo[0]) begin
                    sel.align_err = 1'b1;
                end else begin
                    sel.be = addr_lo[1] ? 4'b1100 : 4'b0011;
                end
            end
            HSIZE_WORD: begin
                if (addr_lo != 2'b00) begin
                    sel.align_err = 1'b1;
                end else begin
                    sel.be = 4'b1111;
                end
            end
            default: sel.align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised RAM with byte-lane writes,
// programmable wait states, two-cycle ERROR response and read-after-write
// forwarding for pipelined transfers.
// Ports:
//   hclk, hresetn        clock (rising edge), async active-low reset
//   hselx, haddr, hwrite, hsize, hburst, hprot, htrans, hready
//                        address-phase inputs from the master/decoder
//   hwdata               write data (data phase)
//   hreadyout, hresp     registered slave ready / response
//   hrdata               registered read data
module ahb_lite_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hselx,
    input  logic [31:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    slave_state_e          state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  dp_valid;
    logic                  dp_write;
    logic [LANES-1:0]      dp_be;
    logic [ADDR_W-1:0]     dp_addr;

    lane_sel_t         lane_sel;
    logic              accept_c;
    logic              range_err_c;
    logic              err_c;
    logic              commit_c;
    logic [ADDR_W-1:0] haddr_word_c;
    logic [ADDR_W-1:0] rd_idx_c;
    logic [DATA_W-1:0] rd_word_c;

    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, htrans[0]};

    ahb_lite_lane_decode u_lane_decode (
        .size    (hsize),
        .addr_lo (haddr[1:0]),
        .sel     (lane_sel)
    );

    assign accept_c     = hselx & hready & htrans[1];
    assign range_err_c  = (haddr >> (ADDR_W + 2)) != '0;
    assign err_c        = lane_sel.align_err | range_err_c;
    assign haddr_word_c = haddr[ADDR_W+1:2];

    // A write data phase ends on the edge where hreadyout is high
    assign commit_c = dp_valid & dp_write & hreadyout;

    // Fresh accept reads via haddr; a wait-stated read uses its stored address
    assign rd_idx_c = (state == ST_WAIT) ? dp_addr : haddr_word_c;

    // RAM read with forwarding of the write committing on this same edge
    always_comb begin : rd_forward
        rd_word_c = mem[rd_idx_c];
        if (commit_c && (dp_addr == rd_idx_c)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (dp_be[i]) begin
                    rd_word_c[8*i +: 8] = hwdata[8*i +: 8];
                end
            end
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge hclk) begin : ram_write
        if (commit_c) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (dp_be[i]) begin
                    mem[dp_addr][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Transfer FSM with registered bus outputs
    always_ff @(posedge hclk or negedge hresetn) begin : fsm
        if (!hresetn) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_be     <= '0;
            dp_addr   <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
        end else begin
            unique case (state)
                // ERR2 completes like IDLE so a new transfer can start on its edge
                ST_IDLE, ST_ERR2: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    dp_valid  <= 1'b0;
                    if (accept_c) begin
                        dp_write <= hwrite;
                        dp_be    <= lane_sel.be;
                        dp_addr  <= haddr_word_c;
                        if (err_c) begin
                            state     <= ST_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= HRESP_ERROR;
                            hrdata    <= '0;
                        end else begin
                            dp_valid <= 1'b1;
                            if (WAIT_STATES > 0) begin
                                state     <= ST_WAIT;
                                hreadyout <= 1'b0;
                                wait_cnt  <= WAIT_CNT_W'(WAIT_STATES - 1);
                            end else if (!hwrite) begin
                                hrdata <= rd_word_c;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        if (!dp_write) begin
                            hrdata <= rd_word_c;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with zero wait
// states and one with two, sharing the address/data bus. Expected results
// are queued when each address phase is driven and checked at completion.
module tb_ahb_lite_sram_slave;

    logic        hclk;
    logic        hresetn;
    logic        sel0;
    logic        sel2;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        rdy0;
    logic        resp0;
    logic [31:0] rdata0;
    logic        rdy2;
    logic        resp2;
    logic [31:0] rdata2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
    } xfer_t;

    xfer_t stim[$];
    xfer_t sb[$];

    ahb_lite_sram_slave #(.ADDR_W(6), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel0), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hready(rdy0), .hwdata(hwdata),
        .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0)
    );

    ahb_lite_sram_slave #(.ADDR_W(6), .WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hresetn(hresetn), .hselx(sel2), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hready(rdy2), .hwdata(hwdata),
        .hreadyout(rdy2), .hresp(resp2), .hrdata(rdata2)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic o_rdy(input int which);
        return (which == 0) ? rdy0 : rdy2;
    endfunction

    function automatic logic o_resp(input int which);
        return (which == 0) ? resp0 : resp2;
    endfunction

    function automatic logic [31:0] o_rdata(input int which);
        return (which == 0) ? rdata0 : rdata2;
    endfunction

    task automatic wr(input string tag, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit err);
        xfer_t x;
        x.tag = tag; x.wr = 1'b1; x.sz = sz; x.addr = a; x.wd = d; x.err = err; x.rd = '0;
        stim.push_back(x);
    endtask

    task automatic rd(input string tag, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] exp, input bit err);
        xfer_t x;
        x.tag = tag; x.wr = 1'b0; x.sz = sz; x.addr = a; x.wd = '0; x.err = err; x.rd = exp;
        stim.push_back(x);
    endtask

    task automatic drive_idle();
        sel0   = 1'b0;
        sel2   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = '0;
        hsize  = 3'd0;
    endtask

    task automatic drive_addr(input int which, input xfer_t x);
        sel0   = (which == 0);
        sel2   = (which != 0);
        htrans = 2'b10;
        hwrite = x.wr;
        haddr  = x.addr;
        hsize  = x.sz;
    endtask

    // Issue queued transfers back-to-back; called and returns at posedge+1
    task automatic run_batch(input int which, input int ws);
        xfer_t cur;
        bit    addr_driven = 1'b0;
        bit    have_dp     = 1'b0;
        int    zeros       = 0;
        int    budget      = 0;
        forever begin
            if (have_dp) begin
                if (o_rdy(which)) begin
                    cur = sb.pop_front();
                    chk({cur.tag, " hresp"}, 32'(o_resp(which)), 32'(cur.err));
                    chk({cur.tag, " waits"}, 32'(zeros), cur.err ? 32'd1 : 32'(ws));
                    if (!cur.wr) chk({cur.tag, " hrdata"}, o_rdata(which), cur.err ? 32'd0 : cur.rd);
                    have_dp = 1'b0;
                end else begin
                    zeros++;
                    chk({sb[0].tag, " wait hresp"}, 32'(o_resp(which)), 32'(sb[0].err));
                end
            end
            if (o_rdy(which) && stim.size() > 0) begin
                cur = stim.pop_front();
                drive_addr(which, cur);
                sb.push_back(cur);
                addr_driven = 1'b1;
            end else begin
                drive_idle();
                addr_driven = 1'b0;
            end
            if (!have_dp && !addr_driven) break;
            @(posedge hclk); #1;
            if (addr_driven) begin
                have_dp = 1'b1;
                zeros   = 0;
                hwdata  = sb[$].wd;
            end
            budget++;
            if (budget > 200) begin
                chk("batch timeout", 32'(have_dp), 32'd0);
                stim.delete();
                sb.delete();
                break;
            end
        end
        drive_idle();
        @(posedge hclk); #1;
    endtask

    initial begin
        hresetn = 1'b0;
        hburst  = 3'd0;
        hprot   = 4'd3;
        hwdata  = '0;
        drive_idle();
        repeat (3) @(posedge hclk);
        #1;
        chk("reset rdy0", 32'(rdy0), 32'd1);
        chk("reset resp0", 32'(resp0), 32'd0);
        chk("reset rdata0", rdata0, 32'd0);
        chk("reset rdy2", 32'(rdy2), 32'd1);
        chk("reset resp2", 32'(resp2), 32'd0);
        chk("reset rdata2", rdata2, 32'd0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Zero-wait word / byte / halfword traffic, pipelined
        wr("w24", 3'd2, 32'h24, 32'hDEADBEEF, 1'b0);
        rd("r24a", 3'd2, 32'h24, 32'hDEADBEEF, 1'b0);
        wr("wb25", 3'd0, 32'h25, 32'h0000_1100, 1'b0);
        rd("r24b", 3'd2, 32'h24, 32'hDEAD11EF, 1'b0);
        wr("wh26", 3'd1, 32'h26, 32'hCAFE_0000, 1'b0);
        rd("r24c", 3'd2, 32'h24, 32'hCAFE11EF, 1'b0);
        run_batch(0, 0);
        rd("r24 ram", 3'd2, 32'h24, 32'hCAFE11EF, 1'b0);
        run_batch(0, 0);

        // Forwarding: RAM holds the old word when the read is accepted
        wr("w10 old", 3'd2, 32'h10, 32'hAAAAAAAA, 1'b0);
        run_batch(0, 0);
        wr("w10 new", 3'd2, 32'h10, 32'h12345678, 1'b0);
        rd("r10 fwd", 3'd2, 32'h10, 32'h12345678, 1'b0);
        run_batch(0, 0);
        rd("r10 ram", 3'd2, 32'h10, 32'h12345678, 1'b0);
        run_batch(0, 0);

        // ERROR responses; master idles in ERR2 and nothing is written
        wr("w00", 3'd2, 32'h00, 32'h5A5A5A5A, 1'b0);
        run_batch(0, 0);
        wr("werr 02", 3'd2, 32'h02, 32'hFFFFFFFF, 1'b1);
        run_batch(0, 0);
        rd("r00 keep", 3'd2, 32'h00, 32'h5A5A5A5A, 1'b0);
        run_batch(0, 0);
        rd("rerr 100", 3'd2, 32'h100, 32'h0, 1'b1);
        run_batch(0, 0);
        wr("werr h01", 3'd1, 32'h01, 32'hFFFFFFFF, 1'b1);
        run_batch(0, 0);
        rd("rerr sz3", 3'd3, 32'h00, 32'h0, 1'b1);
        run_batch(0, 0);
        rd("r00 again", 3'd2, 32'h00, 32'h5A5A5A5A, 1'b0);
        run_batch(0, 0);

        // Two wait states per OKAY transfer
        wr("ws w08", 3'd2, 32'h08, 32'h01020304, 1'b0);
        rd("ws r08", 3'd2, 32'h08, 32'h01020304, 1'b0);
        run_batch(1, 2);
        wr("ws wb0b", 3'd0, 32'h0B, 32'h7700_0000, 1'b0);
        rd("ws r08b", 3'd2, 32'h08, 32'h77020304, 1'b0);
        rd("ws rerr", 3'd2, 32'h0A, 32'h0, 1'b1);
        run_batch(1, 2);

        // Reset during a wait cycle drops the pending write
        wr("ws w0c", 3'd2, 32'h0C, 32'h0C0C0C0C, 1'b0);
        rd("ws r0c", 3'd2, 32'h0C, 32'h0C0C0C0C, 1'b0);
        run_batch(1, 2);
        sel2   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = 32'h0C;
        hsize  = 3'd2;
        @(posedge hclk); #1;
        drive_idle();
        hwdata = 32'hFFFFFFFF;
        chk("rst wait rdy2", 32'(rdy2), 32'd0);
        hresetn = 1'b0;
        #1;
        chk("rst rdy2", 32'(rdy2), 32'd1);
        chk("rst resp2", 32'(resp2), 32'd0);
        chk("rst rdata2", rdata2, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        rd("post rst r0c", 3'd2, 32'h0C, 32'h0C0C0C0C, 1'b0);
        run_batch(1, 2);
        rd("post rst r10", 3'd2, 32'h10, 32'h12345678, 1'b0);
        run_batch(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
